// File: rtl/ltpi_data_channel_req_arbiter_if.sv
// LTPI data-channel types and the requester/TX/RX bundle
// used by the controller-side request arbiter.
package ltpi_dc_pkg;

  localparam int TIMER_1MS_60MHZ = 60000;

  typedef enum logic [3:0] {
    no_link_st,
    link_speed_st,
    link_cfg_st,
    link_accept_st,
    operational_st,
    link_lost_st
  } link_state_t;

  localparam logic [7:0] READ_REQ   = 8'h00;
  localparam logic [7:0] WRITE_REQ  = 8'h01;
  localparam logic [7:0] READ_COMP  = 8'h02;
  localparam logic [7:0] WRITE_COMP = 8'h03;
  localparam logic [7:0] CRC_ERROR  = 8'h04;

  typedef struct packed {
    logic [7:0]  command;
    logic [7:0]  tag;
    logic [15:0] address;
    logic [3:0]  byte_en;
    logic        operation_status;
    logic [31:0] data;
  } Data_channel_payload_t;

endpackage

interface ltpi_data_channel_req_arbiter_if
  import ltpi_dc_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  Data_channel_payload_t [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ack_o;
  Data_channel_payload_t cpl_o;
  logic [NUM_REQ-1:0]    cpl_valid_o;
  Data_channel_payload_t payload_o;
  logic                  payload_o_valid;
  logic                  payload_o_ack;
  Data_channel_payload_t resp_i;
  logic                  resp_i_valid;

  modport master (
    output req_i, req_valid_i,
    output payload_o_ack,
    output resp_i, resp_i_valid,
    input  req_ack_o, cpl_o, cpl_valid_o,
    input  payload_o, payload_o_valid
  );

  modport slave (
    input  req_i, req_valid_i,
    input  payload_o_ack,
    input  resp_i, resp_i_valid,
    output req_ack_o, cpl_o, cpl_valid_o,
    output payload_o, payload_o_valid
  );
endinterface

// File: rtl/ltpi_data_channel_req_arbiter.sv
// Round-robin LTPI data-channel sequencer: one outstanding
// tagged request, response matching, timeout/abort completion.
module ltpi_data_channel_req_arbiter
  import ltpi_dc_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = TIMER_1MS_60MHZ
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_channel_rst,
  input  link_state_t local_link_state,
  ltpi_data_channel_req_arbiter_if.slave bus,
  output logic        busy,
  output logic [15:0] timeout_cnt,
  output logic [15:0] drop_cnt
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RESP,
    COMPLETE
  } state_t;

  state_t                state;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         gnt;
  logic                  gnt_ok;
  logic [7:0]            seq;
  logic [31:0]           timer;
  logic                  rst_any;
  logic                  link_up;
  logic                  resp_match;
  logic                  tmo_hit;
  logic                  drop;
  logic [7:0]            exp_cmd;
  Data_channel_payload_t lat;
  Data_channel_payload_t err_cpl;
  int                    j;

  assign rst_any = reset | data_channel_rst;
  assign link_up = local_link_state == operational_st;
  assign busy    = state != IDLE;

  // first requester after the last winner, wrapping at NUM_REQ
  always_comb begin
    gnt    = '0;
    gnt_ok = 1'b0;
    j      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(rr_ptr) + i) % NUM_REQ;
      if (!gnt_ok && bus.req_valid_i[IW'(j)]) begin
        gnt_ok = 1'b1;
        gnt    = IW'(j);
      end
    end
  end

  always_comb begin
    exp_cmd = (bus.payload_o.command == READ_REQ) ?
              READ_COMP : WRITE_COMP;
    lat     = bus.req_i[gnt];
    lat.tag = seq;
    err_cpl = bus.payload_o;
    err_cpl.command          = exp_cmd;
    err_cpl.operation_status = 1'b1;
    err_cpl.data             = '0;
    resp_match = bus.resp_i_valid &&
                 bus.resp_i.tag == bus.payload_o.tag &&
                 (bus.resp_i.command == exp_cmd ||
                  bus.resp_i.command == CRC_ERROR);
    tmo_hit = timer == 32'(TIMEOUT_CYCLES);
    drop    = bus.resp_i_valid &&
              !(state == WAIT_RESP && resp_match);
  end

  always_ff @(posedge clk or posedge rst_any) begin
    if (rst_any) begin
      state               <= IDLE;
      rr_ptr              <= IW'(NUM_REQ - 1);
      seq                 <= '0;
      timer               <= '0;
      timeout_cnt         <= '0;
      drop_cnt            <= '0;
      bus.req_ack_o       <= '0;
      bus.cpl_valid_o     <= '0;
      bus.cpl_o           <= '0;
      bus.payload_o       <= '0;
      bus.payload_o_valid <= 1'b0;
    end else begin
      bus.req_ack_o   <= '0;
      bus.cpl_valid_o <= '0;
      if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      unique case (state)
        IDLE: begin
          if (link_up && gnt_ok) begin
            bus.payload_o       <= lat;
            bus.payload_o_valid <= 1'b1;
            bus.req_ack_o[gnt]  <= 1'b1;
            rr_ptr              <= gnt;
            state               <= SEND;
          end
        end
        SEND: begin
          if (bus.payload_o_ack)
            seq <= seq + 8'd1;
          if (!link_up) begin
            bus.payload_o_valid    <= 1'b0;
            bus.cpl_o              <= err_cpl;
            bus.cpl_valid_o[rr_ptr] <= 1'b1;
            if (timeout_cnt != 16'hFFFF)
              timeout_cnt <= timeout_cnt + 16'd1;
            state <= COMPLETE;
          end else if (bus.payload_o_ack) begin
            bus.payload_o_valid <= 1'b0;
            timer               <= '0;
            state               <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          timer <= timer + 32'd1;
          // a real response beats a same-cycle timeout/abort
          if (resp_match) begin
            bus.cpl_o               <= bus.resp_i;
            bus.cpl_valid_o[rr_ptr] <= 1'b1;
            state                   <= COMPLETE;
          end else if (!link_up || tmo_hit) begin
            bus.cpl_o               <= err_cpl;
            bus.cpl_valid_o[rr_ptr] <= 1'b1;
            if (timeout_cnt != 16'hFFFF)
              timeout_cnt <= timeout_cnt + 16'd1;
            state <= COMPLETE;
          end
        end
        COMPLETE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltpi_data_channel_req_arbiter.sv
// Directed bench for the LTPI data-channel request arbiter.
// Inputs change and outputs are sampled on the falling edge.
module tb_ltpi_data_channel_req_arbiter;
  import ltpi_dc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_channel_rst = 1'b0;
  link_state_t link = operational_st;
  logic        busy;
  logic [15:0] timeout_cnt;
  logic [15:0] drop_cnt;

  int passed = 0;
  int total  = 0;

  Data_channel_payload_t rq [4];
  Data_channel_payload_t r;
  int  cnt;
  bit  seen;

  ltpi_data_channel_req_arbiter_if #(.NUM_REQ(4)) bus ();

  ltpi_data_channel_req_arbiter #(
    .NUM_REQ       (4),
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .data_channel_rst(data_channel_rst),
    .local_link_state(link),
    .bus             (bus),
    .busy            (busy),
    .timeout_cnt     (timeout_cnt),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                name, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic txn(input int g, input logic [7:0] tg,
                     input bit drop_req, input int rdly);
    int n;
    logic [3:0] oh;
    Data_channel_payload_t rr;
    oh    = '0;
    oh[g] = 1'b1;
    n = 0;
    while (bus.req_ack_o == '0 && n < 20) begin
      step();
      n++;
    end
    chk("ack_lat", n, 1);
    chk("req_ack", bus.req_ack_o, oh);
    chk("tag", bus.payload_o.tag, tg);
    chk("addr", bus.payload_o.address, rq[g].address);
    chk("pvalid", bus.payload_o_valid, 1);
    if (drop_req) bus.req_valid_i[g] = 1'b0;
    bus.payload_o_ack = 1'b1;
    step();
    bus.payload_o_ack = 1'b0;
    chk("pvalid_clr", bus.payload_o_valid, 0);
    repeat (rdly) step();
    rr = '0;
    rr.command = (rq[g].command == READ_REQ) ?
                 READ_COMP : WRITE_COMP;
    rr.tag  = tg;
    rr.data = 32'hD000_0000 | 32'(tg);
    bus.resp_i       = rr;
    bus.resp_i_valid = 1'b1;
    step();
    bus.resp_i_valid = 1'b0;
    chk("cpl_valid", bus.cpl_valid_o, oh);
    chk("cpl_data", bus.cpl_o.data, rr.data);
    step();
    chk("idle", busy, 0);
  endtask

  initial begin
    rq[0] = '{READ_REQ,  8'h55, 16'h0100, 4'hF, 1'b0,
              32'h0};
    rq[1] = '{READ_REQ,  8'h66, 16'h0110, 4'hF, 1'b0,
              32'h1111_2222};
    rq[2] = '{WRITE_REQ, 8'h77, 16'h0200, 4'hF, 1'b0,
              32'h0000_CAFE};
    rq[3] = '{WRITE_REQ, 8'h88, 16'h0300, 4'h3, 1'b0,
              32'h0000_1234};
    for (int i = 0; i < 4; i++) bus.req_i[i] = rq[i];
    bus.req_valid_i   = '0;
    bus.payload_o_ack = 1'b0;
    bus.resp_i        = '0;
    bus.resp_i_valid  = 1'b0;

    // reset values
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_pvalid", bus.payload_o_valid, 0);
    chk("rst_ack", bus.req_ack_o, 0);
    chk("rst_cplv", bus.cpl_valid_o, 0);
    chk("rst_payload", bus.payload_o, 0);
    chk("rst_cpl", bus.cpl_o, 0);
    chk("rst_tmo", timeout_cnt, 0);
    chk("rst_drop", drop_cnt, 0);

    // requesters 0 and 2, grant order 0 then 2
    reset = 1'b0;
    bus.req_valid_i = 4'b0101;
    txn(0, 8'h00, 1'b1, 2);
    txn(2, 8'h01, 1'b1, 2);

    // stray response while idle
    r = '0;
    r.command = READ_COMP;
    r.tag     = 8'h01;
    bus.resp_i       = r;
    bus.resp_i_valid = 1'b1;
    step();
    bus.resp_i_valid = 1'b0;
    chk("idle_drop", drop_cnt, 1);

    // all four valid: 0,1,2,3,0,1,2,3
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("drop_rst", drop_cnt, 0);
    bus.req_valid_i = 4'b1111;
    for (int k = 0; k < 8; k++)
      txn(k % 4, 8'(k), 1'b0, 0);
    bus.req_valid_i = '0;

    // timeout on requester 1
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req_valid_i = 4'b0010;
    step();
    chk("to_ack", bus.req_ack_o, 4'b0010);
    chk("to_tag", bus.payload_o.tag, 0);
    bus.req_valid_i   = '0;
    bus.payload_o_ack = 1'b1;
    step();
    bus.payload_o_ack = 1'b0;
    cnt = 1;
    while (bus.cpl_valid_o == '0 && cnt < 40) begin
      step();
      cnt++;
    end
    chk("to_latency", cnt, 18);
    chk("to_cplv", bus.cpl_valid_o, 4'b0010);
    chk("to_cmd", bus.cpl_o.command, READ_COMP);
    chk("to_status", bus.cpl_o.operation_status, 1);
    chk("to_data", bus.cpl_o.data, 0);
    chk("to_cpl_tag", bus.cpl_o.tag, 0);
    chk("to_cnt", timeout_cnt, 1);

    // wrong tag dropped, right tag completes
    step();
    bus.req_valid_i = 4'b1000;
    step();
    chk("wt_ack", bus.req_ack_o, 4'b1000);
    chk("wt_tag", bus.payload_o.tag, 1);
    bus.req_valid_i   = '0;
    bus.payload_o_ack = 1'b1;
    step();
    bus.payload_o_ack = 1'b0;
    r = '0;
    r.command = WRITE_COMP;
    r.tag     = 8'h5A;
    r.data    = 32'h0000_0BAD;
    bus.resp_i       = r;
    bus.resp_i_valid = 1'b1;
    step();
    bus.resp_i_valid = 1'b0;
    chk("wt_drop", drop_cnt, 1);
    chk("wt_nocpl", bus.cpl_valid_o, 0);
    chk("wt_busy", busy, 1);
    r.tag  = 8'h01;
    r.data = 32'h0000_BEEF;
    bus.resp_i       = r;
    bus.resp_i_valid = 1'b1;
    step();
    bus.resp_i_valid = 1'b0;
    chk("wt_cplv", bus.cpl_valid_o, 4'b1000);
    chk("wt_data", bus.cpl_o.data, 32'h0000_BEEF);
    chk("wt_drop2", drop_cnt, 1);

    // link loss in WAIT_RESP
    step();
    bus.req_valid_i = 4'b0001;
    step();
    chk("ll_ack", bus.req_ack_o, 4'b0001);
    chk("ll_tag", bus.payload_o.tag, 2);
    bus.payload_o_ack = 1'b1;
    step();
    bus.payload_o_ack = 1'b0;
    link = link_cfg_st;
    step();
    chk("ll_cplv", bus.cpl_valid_o, 4'b0001);
    chk("ll_cmd", bus.cpl_o.command, READ_COMP);
    chk("ll_status", bus.cpl_o.operation_status, 1);
    chk("ll_tmo", timeout_cnt, 2);
    seen = 1'b0;
    repeat (6) begin
      step();
      if (bus.req_ack_o != '0) seen = 1'b1;
    end
    chk("ll_nogrant", seen, 0);
    chk("ll_busy", busy, 0);
    link = operational_st;
    step();
    chk("lu_ack", bus.req_ack_o, 4'b0001);
    chk("lu_tag", bus.payload_o.tag, 3);
    chk("lu_pvalid", bus.payload_o_valid, 1);

    // data-channel reset while in SEND
    data_channel_rst = 1'b1;
    #1;
    chk("dr_pvalid", bus.payload_o_valid, 0);
    chk("dr_busy", busy, 0);
    chk("dr_tmo", timeout_cnt, 0);
    seen = bus.cpl_valid_o != '0;
    step();
    if (bus.cpl_valid_o != '0) seen = 1'b1;
    data_channel_rst = 1'b0;
    step();
    if (bus.cpl_valid_o != '0) seen = 1'b1;
    chk("dr_nocpl", seen, 0);
    chk("dr_ack", bus.req_ack_o, 4'b0001);
    chk("dr_tag", bus.payload_o.tag, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
